// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the virtual-channel arbiter: FSM state encoding,
// word width and the bit that selects the destination fifo.
package vc_arbiter_pkg;

  localparam int DATA_W   = 6;
  localparam int DEST_BIT = 4;
  localparam int GRANT_W  = 16;

  typedef enum logic {
    SERVE_VC0 = 1'b0,
    SERVE_VC1 = 1'b1
  } arb_state_e;

  // High when the word is bound for D1, low for D0.
  function automatic logic dest_is_d1(input logic [DATA_W-1:0] word);
    return word[DEST_BIT];
  endfunction

endpackage

// File: rtl/vc_grant_counter.sv
// 16-bit saturating event counter used for per-VC grant statistics.
module vc_grant_counter
  import vc_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_i,
  input  logic               inc_i,
  output logic [GRANT_W-1:0] count_o
);

  logic [GRANT_W-1:0] count_q;
  logic [GRANT_W-1:0] count_d;

  // Increment on each event, sticking at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vc_arbiter.sv
// Weighted round-robin arbiter popping two VC fifos and routing words to D0/D1.
// Define VC_ARB_STATS_EN to enable the saturating grant counters.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int VC0_WEIGHT = 3,
  parameter int VC1_WEIGHT = 1,
  parameter int WEIGHT_W   = 3
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              VC0_EMPTY,
  input  logic              VC1_EMPTY,
  input  logic              VC0_VALID,
  input  logic              VC1_VALID,
  input  logic [DATA_W-1:0] DATA_OUT_VC0,
  input  logic [DATA_W-1:0] DATA_OUT_VC1,
  input  logic              D0_PAUSE,
  input  logic              D1_PAUSE,
  output logic              POP_VC0,
  output logic              POP_VC1,
  output logic              PUSH_D0,
  output logic              PUSH_D1,
  output logic [DATA_W-1:0] DATA_TO_D0,
  output logic [DATA_W-1:0] DATA_TO_D1,
  output logic              ARB_ERR,
  output logic [15:0]       GRANTS_VC0,
  output logic [15:0]       GRANTS_VC1
);

  localparam logic [WEIGHT_W:0] W0_C = (WEIGHT_W+1)'(VC0_WEIGHT);
  localparam logic [WEIGHT_W:0] W1_C = (WEIGHT_W+1)'(VC1_WEIGHT);
  // Credit left after a borrowed grant: a weight-1 VC has already finished its round.
  localparam logic [WEIGHT_W-1:0] BORROW_CR_VC0 = (VC0_WEIGHT == 1) ? '0 : WEIGHT_W'(1);
  localparam logic [WEIGHT_W-1:0] BORROW_CR_VC1 = (VC1_WEIGHT == 1) ? '0 : WEIGHT_W'(1);

  arb_state_e          state_q;
  arb_state_e          state_d;
  logic [WEIGHT_W-1:0] credit_q;
  logic [WEIGHT_W-1:0] credit_d;
  logic [WEIGHT_W:0]   credit_inc_s;
  logic                eligible_s;
  logic                pop_vc0_s;
  logic                pop_vc1_s;

  logic              push_d0_q, push_d0_d;
  logic              push_d1_q, push_d1_d;
  logic [DATA_W-1:0] data_d0_q, data_d0_d;
  logic [DATA_W-1:0] data_d1_q, data_d1_d;
  logic              arb_err_q, arb_err_d;
  logic [DATA_W-1:0] route_word_s;
  logic              route_vld_s;

  assign eligible_s   = ~RESET & ~D0_PAUSE & ~D1_PAUSE;
  assign credit_inc_s = {1'b0, credit_q} + {{WEIGHT_W{1'b0}}, 1'b1};

  // Grant decision: serve the current VC, borrow the other one when current is empty.
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    pop_vc0_s = 1'b0;
    pop_vc1_s = 1'b0;
    if (eligible_s) begin
      case (state_q)
        SERVE_VC0: begin
          if (!VC0_EMPTY) begin
            pop_vc0_s = 1'b1;
            if (credit_inc_s == W0_C) begin
              state_d  = SERVE_VC1;
              credit_d = '0;
            end else begin
              credit_d = credit_inc_s[WEIGHT_W-1:0];
            end
          end else if (!VC1_EMPTY) begin
            pop_vc1_s = 1'b1;
            state_d   = SERVE_VC1;
            credit_d  = BORROW_CR_VC1;
          end else begin
            state_d  = state_q;
            credit_d = credit_q;
          end
        end
        SERVE_VC1: begin
          if (!VC1_EMPTY) begin
            pop_vc1_s = 1'b1;
            if (credit_inc_s == W1_C) begin
              state_d  = SERVE_VC0;
              credit_d = '0;
            end else begin
              credit_d = credit_inc_s[WEIGHT_W-1:0];
            end
          end else if (!VC0_EMPTY) begin
            pop_vc0_s = 1'b1;
            state_d   = SERVE_VC0;
            credit_d  = BORROW_CR_VC0;
          end else begin
            state_d  = state_q;
            credit_d = credit_q;
          end
        end
        default: begin
          state_d  = SERVE_VC0;
          credit_d = '0;
        end
      endcase
    end else begin
      state_d  = state_q;
      credit_d = credit_q;
    end
  end

  // Arbitration state and credit registers.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= SERVE_VC0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  assign POP_VC0 = pop_vc0_s;
  assign POP_VC1 = pop_vc1_s;

  // Routing: VC0 wins a valid collision; the VC1 word is dropped and flagged.
  always_comb begin
    route_vld_s = VC0_VALID | VC1_VALID;
    if (VC0_VALID) begin
      route_word_s = DATA_OUT_VC0;
    end else begin
      route_word_s = DATA_OUT_VC1;
    end
    push_d0_d = route_vld_s & ~dest_is_d1(route_word_s);
    push_d1_d = route_vld_s &  dest_is_d1(route_word_s);
    data_d0_d = push_d0_d ? route_word_s : {DATA_W{1'b0}};
    data_d1_d = push_d1_d ? route_word_s : {DATA_W{1'b0}};
    arb_err_d = VC0_VALID & VC1_VALID;
  end

  // Output stage; reset drops any word still in flight.
  always_ff @(posedge clk) begin
    if (RESET) begin
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_d0_q <= '0;
      data_d1_q <= '0;
      arb_err_q <= 1'b0;
    end else begin
      push_d0_q <= push_d0_d;
      push_d1_q <= push_d1_d;
      data_d0_q <= data_d0_d;
      data_d1_q <= data_d1_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign PUSH_D0    = push_d0_q;
  assign PUSH_D1    = push_d1_q;
  assign DATA_TO_D0 = data_d0_q;
  assign DATA_TO_D1 = data_d1_q;
  assign ARB_ERR    = arb_err_q;

`ifdef VC_ARB_STATS_EN
  vc_grant_counter u_grants_vc0 (
    .clk    (clk),
    .rst_i  (RESET),
    .inc_i  (pop_vc0_s),
    .count_o(GRANTS_VC0)
  );

  vc_grant_counter u_grants_vc1 (
    .clk    (clk),
    .rst_i  (RESET),
    .inc_i  (pop_vc1_s),
    .count_o(GRANTS_VC1)
  );
`else
  assign GRANTS_VC0 = 16'd0;
  assign GRANTS_VC1 = 16'd0;
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: routing vector table plus multi-cycle
// sequences driven through a small fifo model.
module tb_vc_arbiter;

`ifdef VC_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       RESET;
  logic       VC0_EMPTY, VC1_EMPTY;
  logic       VC0_VALID, VC1_VALID;
  logic [5:0] DATA_OUT_VC0, DATA_OUT_VC1;
  logic       D0_PAUSE, D1_PAUSE;
  logic       POP_VC0, POP_VC1;
  logic       PUSH_D0, PUSH_D1;
  logic [5:0] DATA_TO_D0, DATA_TO_D1;
  logic       ARB_ERR;
  logic [15:0] GRANTS_VC0, GRANTS_VC1;

  vc_arbiter dut (
    .clk         (clk),
    .RESET       (RESET),
    .VC0_EMPTY   (VC0_EMPTY),
    .VC1_EMPTY   (VC1_EMPTY),
    .VC0_VALID   (VC0_VALID),
    .VC1_VALID   (VC1_VALID),
    .DATA_OUT_VC0(DATA_OUT_VC0),
    .DATA_OUT_VC1(DATA_OUT_VC1),
    .D0_PAUSE    (D0_PAUSE),
    .D1_PAUSE    (D1_PAUSE),
    .POP_VC0     (POP_VC0),
    .POP_VC1     (POP_VC1),
    .PUSH_D0     (PUSH_D0),
    .PUSH_D1     (PUSH_D1),
    .DATA_TO_D0  (DATA_TO_D0),
    .DATA_TO_D1  (DATA_TO_D1),
    .ARB_ERR     (ARB_ERR),
    .GRANTS_VC0  (GRANTS_VC0),
    .GRANTS_VC1  (GRANTS_VC1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] q0[$];
  logic [5:0] q1[$];

  typedef struct {
    logic       v0, v1;
    logic [5:0] d0, d1;
    logic       e_push0, e_push1;
    logic [5:0] e_data0, e_data1;
    logic       e_err;
  } route_vec_t;

  route_vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_empty();
    VC0_EMPTY = (q0.size() == 0);
    VC1_EMPTY = (q1.size() == 0);
  endtask

  // One clock: fifo model answers pops of this cycle with VALID/data next cycle.
  task automatic tick();
    logic p0, p1;
    p0 = POP_VC0;
    p1 = POP_VC1;
    @(posedge clk);
    #1;
    VC0_VALID = 1'b0; DATA_OUT_VC0 = 6'd0;
    VC1_VALID = 1'b0; DATA_OUT_VC1 = 6'd0;
    if (p0 === 1'b1 && q0.size() > 0) begin
      VC0_VALID = 1'b1; DATA_OUT_VC0 = q0.pop_front();
    end
    if (p1 === 1'b1 && q1.size() > 0) begin
      VC1_VALID = 1'b1; DATA_OUT_VC1 = q1.pop_front();
    end
    set_empty();
    #1;
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    set_empty();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
  endtask

  task automatic chk_push(input string tag, input logic ep0, input logic [5:0] ed0,
                          input logic ep1, input logic [5:0] ed1);
    chk({tag, "_push_d0"}, 16'(PUSH_D0), 16'(ep0));
    chk({tag, "_data_d0"}, 16'(DATA_TO_D0), 16'(ed0));
    chk({tag, "_push_d1"}, 16'(PUSH_D1), 16'(ep1));
    chk({tag, "_data_d1"}, 16'(DATA_TO_D1), 16'(ed1));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 6'b010101, 6'b000000, 1'b0, 1'b1, 6'b000000, 6'b010101, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 6'b101010, 6'b000000, 1'b1, 1'b0, 6'b101010, 6'b000000, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 6'b000000, 6'b011111, 1'b0, 1'b1, 6'b000000, 6'b011111, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 6'b000000, 6'b100001, 1'b1, 1'b0, 6'b100001, 6'b000000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 6'b000110, 6'b010011, 1'b1, 1'b0, 6'b000110, 6'b000000, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 6'b111111, 6'b111111, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 6'b110000, 6'b000001, 1'b0, 1'b1, 6'b000000, 6'b110000, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0};

    RESET = 1'b1;
    D0_PAUSE = 1'b0; D1_PAUSE = 1'b0;
    VC0_VALID = 1'b0; VC1_VALID = 1'b0;
    DATA_OUT_VC0 = 6'd0; DATA_OUT_VC1 = 6'd0;
    q0.push_back(6'h01);
    q1.push_back(6'h02);
    set_empty();
    #1;

    // Reset state with non-empty fifos: nothing popped, all outputs zero.
    tick();
    chk("rst_pop_vc0", 16'(POP_VC0), 16'd0);
    chk("rst_pop_vc1", 16'(POP_VC1), 16'd0);
    chk_push("rst", 1'b0, 6'd0, 1'b0, 6'd0);
    chk("rst_arb_err", 16'(ARB_ERR), 16'd0);
    chk("rst_grants_vc0", GRANTS_VC0, 16'd0);
    chk("rst_grants_vc1", GRANTS_VC1, 16'd0);

    // Routing table: fifos empty, VALID/data forced directly.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      VC0_VALID = vecs[i].v0; DATA_OUT_VC0 = vecs[i].d0;
      VC1_VALID = vecs[i].v1; DATA_OUT_VC1 = vecs[i].d1;
      #1;
      tick();
      chk_push($sformatf("vec%0d", i), vecs[i].e_push0, vecs[i].e_data0,
               vecs[i].e_push1, vecs[i].e_data1);
      chk($sformatf("vec%0d_arb_err", i), 16'(ARB_ERR), 16'(vecs[i].e_err));
    end

    // Both VCs loaded: VC0,VC0,VC0,VC1 repeating.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(6'(i));
      q1.push_back(6'(6'h20 + i));
    end
    set_empty();
    #1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("wrr_c%0d_pop_vc0", c), 16'(POP_VC0), 16'((c % 4) != 3));
      chk($sformatf("wrr_c%0d_pop_vc1", c), 16'(POP_VC1), 16'((c % 4) == 3));
      tick();
    end
    chk("wrr_grants_vc0", GRANTS_VC0, STATS ? 16'd6 : 16'd0);
    chk("wrr_grants_vc1", GRANTS_VC1, STATS ? 16'd2 : 16'd0);

    // VC0 empty: VC1 popped three cycles back to back, each pushed two cycles later.
    do_reset();
    q1.push_back(6'h01);
    q1.push_back(6'h12);
    q1.push_back(6'h23);
    set_empty();
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("vc1only_c%0d_pop_vc0", c), 16'(POP_VC0), 16'd0);
      chk($sformatf("vc1only_c%0d_pop_vc1", c), 16'(POP_VC1), 16'(c < 3));
      chk_push($sformatf("vc1only_c%0d", c),
               (c == 2) || (c == 4), (c == 2) ? 6'h01 : ((c == 4) ? 6'h23 : 6'h00),
               (c == 3), (c == 3) ? 6'h12 : 6'h00);
      tick();
    end

    // D0 pause for five cycles after two VC0 pops; credit and state held.
    do_reset();
    q0.push_back(6'h05);
    q0.push_back(6'b010101);
    q0.push_back(6'h0A);
    q0.push_back(6'h0B);
    q1.push_back(6'h30);
    q1.push_back(6'h31);
    set_empty();
    #1;
    for (int c = 0; c < 9; c++) begin
      D0_PAUSE = (c >= 2) && (c <= 6);
      #1;
      chk($sformatf("pause_c%0d_pop_vc0", c), 16'(POP_VC0), 16'((c < 2) || (c == 7)));
      chk($sformatf("pause_c%0d_pop_vc1", c), 16'(POP_VC1), 16'(c == 8));
      chk_push($sformatf("pause_c%0d", c),
               (c == 2), (c == 2) ? 6'h05 : 6'h00,
               (c == 3), (c == 3) ? 6'b010101 : 6'h00);
      tick();
    end
    D0_PAUSE = 1'b0;

    // RESET while a VC1 word is in flight: dropped, and arbitration restarts at VC0.
    do_reset();
    q1.push_back(6'h12);
    set_empty();
    #1;
    chk("rstmid_c0_pop_vc1", 16'(POP_VC1), 16'd1);
    tick();
    q0.push_back(6'h05);
    q1.push_back(6'h33);
    set_empty();
    RESET = 1'b1;
    #1;
    chk("rstmid_c1_pop_vc0", 16'(POP_VC0), 16'd0);
    chk("rstmid_c1_pop_vc1", 16'(POP_VC1), 16'd0);
    tick();
    RESET = 1'b0;
    #1;
    chk_push("rstmid_c2", 1'b0, 6'd0, 1'b0, 6'd0);
    chk("rstmid_c2_arb_err", 16'(ARB_ERR), 16'd0);
    chk("rstmid_c2_grants_vc0", GRANTS_VC0, 16'd0);
    chk("rstmid_c2_grants_vc1", GRANTS_VC1, 16'd0);
    chk("rstmid_c2_pop_vc0", 16'(POP_VC0), 16'd1);
    chk("rstmid_c2_pop_vc1", 16'(POP_VC1), 16'd0);
    tick();
    tick();
    chk_push("rstmid_c4", 1'b1, 6'h05, 1'b0, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
